healthcare_monitor_second_phase: RTL

Sequential, multi-patient successor to the phase-one combinational health checker. It accepts per-sample abnormality flags plus a glycemic index for NUM_CH monitored channels. A flag becomes an alarm only after it persists for PERSIST consecutive samples on the same channel. Alarms latch until reported, and a round-robin scanner emits one alarm record per channel over a valid/ready port to the downstream display/logging block.

---
 rtl/healthcare_pkg.sv | 18 +
 rtl/hc_persist_counter.sv | 29 ++
 rtl/healthcare_monitor_second_phase.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/healthcare_pkg.sv
// Shared definitions for the second-phase health monitor: alarm bit map and FSM states.
package healthcare_pkg;

  localparam int unsigned NUM_ALARMS = 5;

  // Alarm bit positions inside a per-channel alarm vector
  localparam int unsigned PRESSURE = 0;
  localparam int unsigned BLOOD    = 1;
  localparam int unsigned FALL     = 2;
  localparam int unsigned TEMP     = 3;
  localparam int unsigned GLYCEMIC = 4;

  typedef enum logic [0:0] {
    StScan,
    StReport
  } hcState_e;

endpackage

// File: rtl/hc_persist_counter.sv
// Saturating persistence counter: counts consecutive abnormal samples for one channel/bit.
module hc_persist_counter #(
  parameter int unsigned PERSIST = 3,
  localparam int unsigned CNT_W  = $clog2(PERSIST + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic reachedPulse
);

  logic [CNT_W-1:0] cntQ;

  // Clear has priority; increment stops at PERSIST
  always_ff @(posedge clk) begin
    if (rst) begin
      cntQ <= '0;
    end else if (clr) begin
      cntQ <= '0;
    end else if (inc && (cntQ != CNT_W'(PERSIST))) begin
      cntQ <= cntQ + 1'b1;
    end
  end

  // High only on the increment that lands exactly on PERSIST, never while saturated
  assign reachedPulse = inc && !clr && (cntQ == CNT_W'(PERSIST - 1));

endmodule

// File: rtl/healthcare_monitor_second_phase.sv
// Multi-channel health monitor: persistence filtering, latched alarms and round-robin reporting.
module healthcare_monitor_second_phase
  import healthcare_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned PERSIST        = 3,
  parameter int unsigned GI_LIMIT       = 8,
  parameter bit          FALL_IMMEDIATE = 1'b1,
  localparam int unsigned CH_W          = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     chEnable,
  input  logic                  sampleValid,
  output logic                  sampleReady,
  input  logic [CH_W-1:0]       sampleCh,
  input  logic [3:0]            sampleFlags,
  input  logic [3:0]            glycemicIndex,
  output logic                  sampleDropped,
  output logic                  reportValid,
  input  logic                  reportReady,
  output logic [CH_W-1:0]       reportCh,
  output logic [NUM_ALARMS-1:0] reportAlarms,
  output logic                  alarmAny
);

  logic                               readyQ;
  logic                               dropQ, dropD;
  logic                               alarmAnyQ;
  logic                               accept;
  logic [NUM_ALARMS-1:0]              sampleBits;
  logic [NUM_CH-1:0]                  chHit;
  logic [NUM_CH-1:0][NUM_ALARMS-1:0]  setMask;
  logic [NUM_CH-1:0][NUM_ALARMS-1:0]  clrMask;
  logic [NUM_CH-1:0][NUM_ALARMS-1:0]  pendingQ;

  hcState_e              stateQ, stateD;
  logic [CH_W-1:0]       ptrQ, ptrD, ptrNext;
  logic                  validQ, validD;
  logic [CH_W-1:0]       chQ, chD;
  logic [NUM_ALARMS-1:0] alarmsQ, alarmsD;
  logic                  rptAccept;

  assign accept     = sampleValid & readyQ;
  assign sampleBits = {(glycemicIndex >= 4'(GI_LIMIT)), sampleFlags};

  // One-hot decode of the sample's channel; out-of-range channels decode to nothing
  always_comb begin
    chHit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      chHit[c] = accept && (sampleCh == CH_W'(c));
    end
  end

  assign dropD = accept && ((chHit & chEnable) == '0);

  // Counter array: a disabled-channel sample clears every counter of that channel
  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    for (genvar b = 0; b < NUM_ALARMS; b++) begin : gBit
      logic inc, clr, reached;

      assign inc = chHit[c] & chEnable[c] & sampleBits[b];
      assign clr = chHit[c] & ~(chEnable[c] & sampleBits[b]);

      hc_persist_counter #(
        .PERSIST (PERSIST)
      ) uCnt (
        .clk          (clk),
        .rst          (rst),
        .inc          (inc),
        .clr          (clr),
        .reachedPulse (reached)
      );

      if ((b == FALL) && FALL_IMMEDIATE) begin : gFallFast
        assign setMask[c][b] = reached | inc;
      end else begin : gPersist
        assign setMask[c][b] = reached;
      end
    end
  end

  // Report acceptance clears only the bits that were captured in the record
  always_comb begin
    clrMask = '0;
    if (rptAccept) begin
      clrMask[ptrQ] = alarmsQ;
    end
  end

  // Pending alarm latches; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      pendingQ <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        pendingQ[c] <= (pendingQ[c] & ~clrMask[c]) | setMask[c];
      end
    end
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      readyQ    <= 1'b0;
      dropQ     <= 1'b0;
      alarmAnyQ <= 1'b0;
    end else begin
      readyQ    <= 1'b1;
      dropQ     <= dropD;
      alarmAnyQ <= |pendingQ;
    end
  end

  // Scanner state and held report record
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= StScan;
      ptrQ    <= '0;
      validQ  <= 1'b0;
      chQ     <= '0;
      alarmsQ <= '0;
    end else begin
      stateQ  <= stateD;
      ptrQ    <= ptrD;
      validQ  <= validD;
      chQ     <= chD;
      alarmsQ <= alarmsD;
    end
  end

  assign ptrNext = (ptrQ == CH_W'(NUM_CH - 1)) ? '0 : ptrQ + 1'b1;

  // Round-robin scan / report handshake next-state logic
  always_comb begin
    stateD    = stateQ;
    ptrD      = ptrQ;
    validD    = validQ;
    chD       = chQ;
    alarmsD   = alarmsQ;
    rptAccept = 1'b0;
    unique case (stateQ)
      StScan: begin
        if (pendingQ[ptrQ] != '0) begin
          chD     = ptrQ;
          alarmsD = pendingQ[ptrQ];
          validD  = 1'b1;
          stateD  = StReport;
        end else begin
          ptrD = ptrNext;
        end
      end
      StReport: begin
        if (reportReady) begin
          rptAccept = 1'b1;
          validD    = 1'b0;
          ptrD      = ptrNext;
          stateD    = StScan;
        end
      end
      default: stateD = StScan;
    endcase
  end

  assign sampleReady   = readyQ;
  assign sampleDropped = dropQ;
  assign alarmAny      = alarmAnyQ;
  assign reportValid   = validQ;
  assign reportCh      = chQ;
  assign reportAlarms  = alarmsQ;

endmodule
